game_ctrl: RTL and testbench
============================

// Module: game_ctrl
// PURPOSE
//  Frame-level game sequencer for the VGA pipeline (timing -> background -> ship -> textbox).
//  Derives a once-per-frame tick from blanking and runs the TITLE/PLAY/DEAD/OVER state machine.
//  Tracks lives, score and wave level.
//  Drives enables for ship/enemy movement and the textbox message select, so all movers update once per frame, during vblank.
// PARAMETERS
//  LIVES_INIT      3     lives loaded on game start (1..3)
//  PTS_PER_HIT     10    score increment per enemy hit
//  SCORE_MAX       9999  score saturation value (fits 14 bits)
//  RESPAWN_FRAMES  120   frames spent in DEAD before returning to PLAY
//  OVER_FRAMES     240   frames spent in OVER before returning to TITLE
//  LEVEL_MAX       7     wave level saturation value (3 bits)
// PORTS
//  pclk          in   1   pixel clock, 65 MHz
//  rst           in   1   synchronous, active-high reset
//  vblnk_in      in   1   vertical blank from the timing chain
//  start_button  in   1   fire/start button, already synchronised and delayed upstream
//  hit_enemy     in   1   1-cycle pulse: missile hit an enemy
//  hit_player    in   1   1-cycle pulse: enemy/projectile hit ship
//  wave_clear    in   1   1-cycle pulse: all enemies of wave destroyed
//  frame_tick    out  1   1-cycle pulse per frame
//  game_state    out  2   0=TITLE 1=PLAY 2=DEAD 3=OVER
//  ship_en       out  1   ship may move/fire (state==PLAY)
//  enemy_en      out  1   enemies may move (PLAY or DEAD)
//  lives         out  2   remaining lives
//  score         out  14  binary score, saturating
//  level         out  3   wave level, saturating
// BEHAVIOUR
//  - All outputs registered. Reset values: game_state=TITLE; lives=0, score=0, level=0; frame_tick=0, ship_en=0, enemy_en=0; internal edge regs=0; frame counter=0.
//  - frame_tick: vblnk_d <= vblnk_in; frame_tick <= vblnk_in & ~vblnk_d.
//    The pulse is high the cycle after the first high vblnk_in sample.
//    The first vblnk after reset produces a tick.
//  - start_press = start_button & ~start_d (rising edge, registered compare). Held button = one press.
//  - hit_enemy, hit_player and wave_clear are acted on only in PLAY; ignored in every other state.
//  - TITLE: start_press -> PLAY next cycle.
//    On that same cycle: lives<=LIVES_INIT, score<=0, level<=0, frame counter cleared.
//  - PLAY:
//    - hit_enemy: score <= min(score+PTS_PER_HIT, SCORE_MAX). Compute in 15 bits, then clamp.
//    - wave_clear: level <= level+1, saturating at LEVEL_MAX.
//    - hit_player with lives>1: lives--, counter<=0, -> DEAD.
//    - hit_player with lives==1: lives<=0, counter<=0, -> OVER.
//    - Simultaneous events in one cycle are all applied. Example: hit_enemy+hit_player scores AND loses a life.
//    - start_press has no effect.
//  - DEAD: counter increments on frame_tick only.
//    When counter==RESPAWN_FRAMES-1 and frame_tick -> PLAY, counter<=0.
//  - OVER: same counting with OVER_FRAMES -> TITLE.
//    score/level hold for display until the next game start. start_press is ignored.
//  - Frame counter: 8 bits minimum; width = clog2(max(RESPAWN_FRAMES, OVER_FRAMES)).
//  - ship_en/enemy_en/game_state are registered from the next-state value, so they change in the same cycle as game_state.
//  - rst asserted mid-game: next edge forces all reset values; any in-flight pulse is dropped.
// TESTING
//  1. rst 2 cycles, then vblnk_in 0->1 held for 10 cycles -> exactly one frame_tick, 1 cycle after vblnk_in rises.
//     Outputs before that: state=0, lives=0, score=0.
//  2. TITLE, hold start_button 50 cycles -> one transition to PLAY.
//     lives=3, score=0, ship_en=1, enemy_en=1; no re-trigger.
//  3. PLAY, 1000 hit_enemy pulses -> score saturates at 9999 (PTS 10 => reached at 1000th hit) and stays 9999.
//     8 wave_clear pulses -> level 7.
//  4. PLAY lives=3, hit_player -> state=DEAD, lives=2, ship_en=0, enemy_en=1.
//     hit_enemy during DEAD ignored; after exactly 120 frame_ticks -> PLAY.
//  5. lives=1, hit_enemy+hit_player in same cycle -> score+10, lives=0, state=OVER.
//     start_press ignored; after 240 ticks -> TITLE with score held.
//  6. rst asserted while DEAD with counter=60 -> TITLE, all zero next cycle.
//     Following start -> fresh game with lives=3.

Source files
------------

// File: rtl/game_ctrl.sv
// Frame-level game sequencer: derives a per-frame tick from vblank and runs
// the TITLE/PLAY/DEAD/OVER machine with lives, score and wave level.
module game_ctrl #(
  parameter int LIVES_INIT     = 3,
  parameter int PTS_PER_HIT    = 10,
  parameter int SCORE_MAX      = 9999,
  parameter int RESPAWN_FRAMES = 120,
  parameter int OVER_FRAMES    = 240,
  parameter int LEVEL_MAX      = 7
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        vblnk_in,
  input  logic        start_button,
  input  logic        hit_enemy,
  input  logic        hit_player,
  input  logic        wave_clear,
  output logic        frame_tick,
  output logic [1:0]  game_state,
  output logic        ship_en,
  output logic        enemy_en,
  output logic [1:0]  lives,
  output logic [13:0] score,
  output logic [2:0]  level
);

  localparam int FMAX = (RESPAWN_FRAMES > OVER_FRAMES) ? RESPAWN_FRAMES : OVER_FRAMES;
  localparam int CW   = ($clog2(FMAX) > 8) ? $clog2(FMAX) : 8;

  typedef enum logic [1:0] {TITLE = 2'd0, PLAY = 2'd1, DEAD = 2'd2, OVER = 2'd3} state_t;

  state_t        state, state_nx;
  logic          vblnk_d, start_d, start_press;
  logic [CW-1:0] cnt, cnt_nx;
  logic [1:0]    lives_nx;
  logic [13:0]   score_nx;
  logic [2:0]    level_nx;
  logic [14:0]   score_sum;

  assign start_press = start_button & ~start_d;
  assign game_state  = state;
  // One extra bit so the sum cannot wrap before the clamp.
  assign score_sum   = {1'b0, score} + 15'(PTS_PER_HIT);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    lives_nx = lives;
    score_nx = score;
    level_nx = level;
    case (state)
      TITLE: begin
        if (start_press) begin
          state_nx = PLAY;
          lives_nx = 2'(LIVES_INIT);
          score_nx = '0;
          level_nx = '0;
          cnt_nx   = '0;
        end
      end
      PLAY: begin
        if (hit_enemy)
          score_nx = (score_sum > 15'(SCORE_MAX)) ? 14'(SCORE_MAX) : score_sum[13:0];
        if (wave_clear && level < 3'(LEVEL_MAX))
          level_nx = level + 3'd1;
        if (hit_player) begin
          cnt_nx = '0;
          if (lives > 2'd1) begin
            lives_nx = lives - 2'd1;
            state_nx = DEAD;
          end else begin
            lives_nx = '0;
            state_nx = OVER;
          end
        end
      end
      DEAD: begin
        if (frame_tick) begin
          if (cnt == CW'(RESPAWN_FRAMES - 1)) begin
            state_nx = PLAY;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
      end
      OVER: begin
        if (frame_tick) begin
          if (cnt == CW'(OVER_FRAMES - 1)) begin
            state_nx = TITLE;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
      end
      default: state_nx = TITLE;
    endcase
  end

  // Enables come from the next state so they flip on the same edge as game_state.
  always_ff @(posedge pclk) begin
    if (rst) begin
      state      <= TITLE;
      cnt        <= '0;
      lives      <= '0;
      score      <= '0;
      level      <= '0;
      vblnk_d    <= 1'b0;
      start_d    <= 1'b0;
      frame_tick <= 1'b0;
      ship_en    <= 1'b0;
      enemy_en   <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      lives      <= lives_nx;
      score      <= score_nx;
      level      <= level_nx;
      vblnk_d    <= vblnk_in;
      start_d    <= start_button;
      frame_tick <= vblnk_in & ~vblnk_d;
      ship_en    <= (state_nx == PLAY);
      enemy_en   <= (state_nx == PLAY) || (state_nx == DEAD);
    end
  end

endmodule

// File: tb/tb_game_ctrl.sv
// Scoreboard bench for game_ctrl: stimulus queues expected outputs tagged
// with a cycle number; the monitor pops and compares them on the falling edge.
module tb_game_ctrl;

  logic        pclk = 1'b0;
  logic        rst, vblnk_in, start_button, hit_enemy, hit_player, wave_clear;
  logic        frame_tick, ship_en, enemy_en;
  logic [1:0]  game_state, lives;
  logic [13:0] score;
  logic [2:0]  level;

  game_ctrl dut (
    .pclk(pclk), .rst(rst), .vblnk_in(vblnk_in), .start_button(start_button),
    .hit_enemy(hit_enemy), .hit_player(hit_player), .wave_clear(wave_clear),
    .frame_tick(frame_tick), .game_state(game_state), .ship_en(ship_en),
    .enemy_en(enemy_en), .lives(lives), .score(score), .level(level)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    int          cyc;
    string       nm;
    logic        tick;
    logic [1:0]  st;
    logic [1:0]  lv;
    logic [13:0] sc;
    logic [2:0]  lvl;
    logic        sh;
    logic        en;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always @(posedge pclk) cyc <= cyc + 1;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge pclk);
      #1;
    end
  endtask

  task automatic push(input string nm, input int d);
    exp_t t;
    t = e;
    t.nm = nm;
    t.cyc = cyc + d;
    q.push_back(t);
  endtask

  task automatic frame();
    vblnk_in = 1'b1;
    step(2);
    vblnk_in = 1'b0;
    step(2);
  endtask

  // Final frame of a DEAD/OVER period: tick seen in old state, new state next cycle.
  task automatic last_frame(input string nm, input logic [1:0] st, input logic sh, input logic en);
    vblnk_in = 1'b1;
    e.tick = 1'b1;
    push({nm, "_tick"}, 1);
    e.tick = 1'b0;
    e.st = st;
    e.sh = sh;
    e.en = en;
    push(nm, 2);
    step(2);
    vblnk_in = 1'b0;
    step(2);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge pclk);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        x = q.pop_front();
        n_tests++;
        if (x.cyc < cyc) begin
          n_fail++;
          $display("FAIL %s: check for cycle %0d missed (now %0d)", x.nm, x.cyc, cyc);
        end else if ({frame_tick, game_state, lives, score, level, ship_en, enemy_en} !==
                     {x.tick, x.st, x.lv, x.sc, x.lvl, x.sh, x.en}) begin
          n_fail++;
          $display("FAIL %s cyc=%0d got tick=%b st=%0d lives=%0d score=%0d level=%0d ship=%b enemy=%b want tick=%b st=%0d lives=%0d score=%0d level=%0d ship=%b enemy=%b",
                   x.nm, cyc, frame_tick, game_state, lives, score, level, ship_en, enemy_en,
                   x.tick, x.st, x.lv, x.sc, x.lvl, x.sh, x.en);
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    rst = 1'b1; vblnk_in = 1'b0; start_button = 1'b0;
    hit_enemy = 1'b0; hit_player = 1'b0; wave_clear = 1'b0;
    e.tick = 0; e.st = 0; e.lv = 0; e.sc = 0; e.lvl = 0; e.sh = 0; e.en = 0;
    e.nm = ""; e.cyc = 0;

    // Reset and the first vblank tick
    step(1);
    push("rst", 1);
    step(1);
    rst = 1'b0;
    push("post_rst", 1);
    step(1);
    hit_enemy = 1'b1;
    push("title_hit_ign", 1);
    step(1);
    hit_enemy = 1'b0;
    vblnk_in = 1'b1;
    e.tick = 1'b1;
    push("tick_rise", 1);
    e.tick = 1'b0;
    for (int i = 2; i <= 10; i++) push("tick_once", i);
    step(10);
    vblnk_in = 1'b0;
    step(2);

    // Start from TITLE, button held
    start_button = 1'b1;
    e.st = 1; e.lv = 3; e.sh = 1; e.en = 1;
    push("start", 1);
    push("start_held", 49);
    step(50);
    start_button = 1'b0;
    step(1);

    // First death and respawn after 120 frames
    hit_player = 1'b1;
    e.st = 2; e.lv = 2; e.sh = 0;
    push("die1", 1);
    step(1);
    hit_player = 1'b0;
    hit_enemy = 1'b1; wave_clear = 1'b1;
    push("dead_ign", 1);
    step(1);
    hit_enemy = 1'b0; wave_clear = 1'b0;
    repeat (119) frame();
    push("dead_119", 1);
    step(1);
    last_frame("respawn1", 2'd1, 1'b1, 1'b1);

    // Second death down to one life
    hit_player = 1'b1;
    e.st = 2; e.lv = 1; e.sh = 0;
    push("die2", 1);
    step(1);
    hit_player = 1'b0;
    repeat (119) frame();
    last_frame("respawn2", 2'd1, 1'b1, 1'b1);

    // Last life: score and death in the same cycle
    hit_enemy = 1'b1; hit_player = 1'b1;
    e.sc = 10; e.lv = 0; e.st = 3; e.sh = 0; e.en = 0;
    push("over", 1);
    step(1);
    hit_enemy = 1'b0; hit_player = 1'b0;
    start_button = 1'b1;
    push("over_start_ign", 1);
    step(1);
    start_button = 1'b0;
    step(1);
    repeat (239) frame();
    push("over_239", 1);
    step(1);
    last_frame("to_title", 2'd0, 1'b0, 1'b0);
    push("title_hold", 1);
    step(1);

    // New game, score saturation and level saturation
    start_button = 1'b1;
    e.st = 1; e.lv = 3; e.sc = 0; e.lvl = 0; e.sh = 1; e.en = 1;
    push("restart", 1);
    step(1);
    start_button = 1'b0;
    for (int k = 1; k <= 1001; k++) begin
      hit_enemy = 1'b1;
      e.sc = (k * 10 > 9999) ? 14'd9999 : 14'(k * 10);
      if (k == 1 || k == 500 || k == 999 || k == 1000 || k == 1001) push("score", 1);
      step(1);
      hit_enemy = 1'b0;
      step(1);
    end
    for (int k = 1; k <= 8; k++) begin
      wave_clear = 1'b1;
      e.lvl = (k > 7) ? 3'd7 : 3'(k);
      push("level", 1);
      step(1);
      wave_clear = 1'b0;
      step(1);
    end

    // Reset in the middle of a DEAD period
    hit_player = 1'b1;
    e.st = 2; e.lv = 2; e.sh = 0;
    push("die3", 1);
    step(1);
    hit_player = 1'b0;
    repeat (60) frame();
    push("dead60", 1);
    step(1);
    rst = 1'b1;
    vblnk_in = 1'b1;
    e.st = 0; e.lv = 0; e.sc = 0; e.lvl = 0; e.sh = 0; e.en = 0; e.tick = 0;
    push("mid_rst", 1);
    step(1);
    rst = 1'b0;
    vblnk_in = 1'b0;
    step(1);
    start_button = 1'b1;
    e.st = 1; e.lv = 3; e.sh = 1; e.en = 1;
    push("fresh", 1);
    step(1);
    start_button = 1'b0;
    step(3);

    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d checks left unmatched, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
